// File: rtl/aixh_mxc_left_seq_pkg.sv
// Shared types for the MxConv left-column sequencer.
package AIXH_MXC_pkg;

   // Widest loop field the sequencer supports. Narrower command fields are
   // zero-extended to this width, which leaves the '==' loop compares unchanged.
   localparam int MXC_LSEQ_CNT_MAX_W = 16;

   typedef enum logic [2:0] {
      LSEQ_IDLE   = 3'd0,
      LSEQ_FILL   = 3'd1,
      LSEQ_STREAM = 3'd2,
      LSEQ_DRAIN  = 3'd3,
      LSEQ_DONE   = 3'd4
   } mxc_lseq_state_t;

   typedef struct packed {
      logic [MXC_LSEQ_CNT_MAX_W-1:0] icnt;
      logic [MXC_LSEQ_CNT_MAX_W-1:0] ocnt;
      logic [MXC_LSEQ_CNT_MAX_W-1:0] len;
      logic [1:0]                    rmode;
   } mxc_lseq_cmd_t;

endpackage

// File: rtl/aixh_mxc_left_seq_cnt.sv
// Nested row / input-group / output-group counter for the left sequencer.
// Row wraps to zero on its last value; a group step moves ic, then oc.
module aixh_mxc_left_seq_cnt
   import AIXH_MXC_pkg::*;
#(
   parameter int CNT_W = MXC_LSEQ_CNT_MAX_W
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_clr,
   input  logic             i_adv,
   input  logic             i_step,
   input  logic [CNT_W-1:0] i_icnt,
   input  logic [CNT_W-1:0] i_ocnt,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_first_row,
   output logic             o_last_row,
   output logic             o_last_ic,
   output logic             o_last_oc
);

   logic [CNT_W-1:0] r_row;
   logic [CNT_W-1:0] r_ic;
   logic [CNT_W-1:0] r_oc;

   assign o_first_row = (r_row == '0);
   assign o_last_row  = (r_row == i_len);
   assign o_last_ic   = (r_ic  == i_icnt);
   assign o_last_oc   = (r_oc  == i_ocnt);

   // Row advances per issued enable; the group step applies on the last read.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_row <= '0;
         r_ic  <= '0;
         r_oc  <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_ic  <= '0;
         r_oc  <= '0;
      end else begin
         if (i_adv) begin
            r_row <= o_last_row ? '0 : r_row + CNT_W'(1);
         end
         if (i_step) begin
            if (!o_last_ic) begin
               r_ic <= r_ic + CNT_W'(1);
            end else begin
               r_ic <= '0;
               if (!o_last_oc) begin
                  r_oc <= r_oc + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/aixh_mxc_left_seq.sv
// MxConv left-column sequencer: expands one layer-pass command into the
// FILL (queue write) / STREAM (queue read) control stream for every
// output-group x input-group, then drains and signals completion.
// Every output is registered from the cycle's decision, so an input sampled
// in cycle c shows up on the enables in cycle c+1.
module aixh_mxc_left_seq
   import AIXH_MXC_pkg::*;
#(
   parameter int CNT_W     = 12,
   parameter int DRAIN_LAT = 8
) (
   input  logic             aixh_core_clk,
   input  logic             aixh_core_rstn,
   input  logic             i_cmd_vld,
   output logic             o_cmd_rdy,
   input  logic [CNT_W-1:0] i_cmd_icnt,
   input  logic [CNT_W-1:0] i_cmd_ocnt,
   input  logic [CNT_W-1:0] i_cmd_len,
   input  logic [1:0]       i_cmd_rmode,
   input  logic             i_ltc_vld,
   input  logic             i_stall,
   output logic             o_dwd_wenable,
   output logic             o_dwd_renable,
   output logic [1:0]       o_dwd_rmode,
   output logic             o_dwd_icsync,
   output logic             o_dwd_ocsync,
   output logic             o_busy,
   output logic             o_done
);

   mxc_lseq_state_t r_state, w_nxt;
   mxc_lseq_cmd_t   r_cmd;
   logic [7:0]      r_drn;

   logic w_acc, w_clr, w_adv, w_step;
   logic w_wen, w_ren, w_ics, w_ocs;
   logic w_first_row, w_last_row, w_last_ic, w_last_oc;

   logic r_rdy, r_wen, r_ren, r_ics, r_ocs, r_busy, r_done;

   assign w_acc = i_cmd_vld & r_rdy;

   aixh_mxc_left_seq_cnt #(
      .CNT_W (MXC_LSEQ_CNT_MAX_W)
   ) u_cnt (
      .i_clk       (aixh_core_clk),
      .i_rstn      (aixh_core_rstn),
      .i_clr       (w_clr),
      .i_adv       (w_adv),
      .i_step      (w_step),
      .i_icnt      (r_cmd.icnt),
      .i_ocnt      (r_cmd.ocnt),
      .i_len       (r_cmd.len),
      .o_first_row (w_first_row),
      .o_last_row  (w_last_row),
      .o_last_ic   (w_last_ic),
      .o_last_oc   (w_last_oc)
   );

   // State register.
   always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
      if (!aixh_core_rstn) r_state <= LSEQ_IDLE;
      else                 r_state <= w_nxt;
   end

   // Next state, counter control and the enables to be registered.
   always_comb begin
      w_nxt  = r_state;
      w_clr  = 1'b0;
      w_adv  = 1'b0;
      w_step = 1'b0;
      w_wen  = 1'b0;
      w_ren  = 1'b0;
      w_ics  = 1'b0;
      w_ocs  = 1'b0;
      case (r_state)
         LSEQ_IDLE: begin
            if (w_acc) begin
               w_clr = 1'b1;
               w_nxt = LSEQ_FILL;
            end
         end
         LSEQ_FILL: begin
            if (i_ltc_vld) begin
               w_wen = 1'b1;
               w_adv = 1'b1;
               if (w_last_row) w_nxt = LSEQ_STREAM;
            end
         end
         LSEQ_STREAM: begin
            if (!i_stall) begin
               w_ren = 1'b1;
               w_adv = 1'b1;
               w_ics = w_first_row;
               w_ocs = w_last_row & w_last_ic;
               if (w_last_row) begin
                  w_step = 1'b1;
                  w_nxt  = (w_last_ic && w_last_oc) ? LSEQ_DRAIN : LSEQ_FILL;
               end
            end
         end
         LSEQ_DRAIN: begin
            if (r_drn == 8'(DRAIN_LAT)) w_nxt = LSEQ_DONE;
         end
         LSEQ_DONE: begin
            w_nxt = LSEQ_IDLE;
         end
         default: begin
            w_nxt = LSEQ_IDLE;
         end
      endcase
   end

   // Command latch; rmode is held on the output until the next acceptance.
   always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
      if (!aixh_core_rstn) begin
         r_cmd <= '0;
      end else if (w_acc) begin
         r_cmd.icnt  <= MXC_LSEQ_CNT_MAX_W'(i_cmd_icnt);
         r_cmd.ocnt  <= MXC_LSEQ_CNT_MAX_W'(i_cmd_ocnt);
         r_cmd.len   <= MXC_LSEQ_CNT_MAX_W'(i_cmd_len);
         r_cmd.rmode <= i_cmd_rmode;
      end
   end

   // Drain timer: counts from 0 on DRAIN entry, so DONE follows after
   // DRAIN_LAT+1 DRAIN cycles and o_done lands DRAIN_LAT+1 after the last read.
   always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
      if (!aixh_core_rstn)               r_drn <= '0;
      else if (r_state == LSEQ_DRAIN)    r_drn <= r_drn + 8'd1;
      else                               r_drn <= '0;
   end

   // Output flops; status outputs follow the next state so they line up with it.
   always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
      if (!aixh_core_rstn) begin
         r_rdy  <= 1'b1;
         r_wen  <= 1'b0;
         r_ren  <= 1'b0;
         r_ics  <= 1'b0;
         r_ocs  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_rdy  <= (w_nxt == LSEQ_IDLE);
         r_wen  <= w_wen;
         r_ren  <= w_ren;
         r_ics  <= w_ics;
         r_ocs  <= w_ocs;
         r_busy <= (w_nxt != LSEQ_IDLE);
         r_done <= (w_nxt == LSEQ_DONE);
      end
   end

   assign o_cmd_rdy     = r_rdy;
   assign o_dwd_wenable = r_wen;
   assign o_dwd_renable = r_ren;
   assign o_dwd_rmode   = r_cmd.rmode;
   assign o_dwd_icsync  = r_ics;
   assign o_dwd_ocsync  = r_ocs;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule

// File: tb/tb_aixh_mxc_left_seq.sv
// Testbench for aixh_mxc_left_seq: scoreboard of expected enable cycles
// plus per-scenario timing checks.
module tb_aixh_mxc_left_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_cmd_vld = 1'b0;
   logic        o_cmd_rdy;
   logic [11:0] i_cmd_icnt = '0;
   logic [11:0] i_cmd_ocnt = '0;
   logic [11:0] i_cmd_len = '0;
   logic [1:0]  i_cmd_rmode = '0;
   logic        i_ltc_vld = 1'b0;
   logic        i_stall = 1'b0;
   logic        o_dwd_wenable, o_dwd_renable, o_dwd_icsync, o_dwd_ocsync;
   logic [1:0]  o_dwd_rmode;
   logic        o_busy, o_done;

   aixh_mxc_left_seq #(.CNT_W(12), .DRAIN_LAT(8)) dut (
      .aixh_core_clk  (clk),
      .aixh_core_rstn (rstn),
      .i_cmd_vld      (i_cmd_vld),
      .o_cmd_rdy      (o_cmd_rdy),
      .i_cmd_icnt     (i_cmd_icnt),
      .i_cmd_ocnt     (i_cmd_ocnt),
      .i_cmd_len      (i_cmd_len),
      .i_cmd_rmode    (i_cmd_rmode),
      .i_ltc_vld      (i_ltc_vld),
      .i_stall        (i_stall),
      .o_dwd_wenable  (o_dwd_wenable),
      .o_dwd_renable  (o_dwd_renable),
      .o_dwd_rmode    (o_dwd_rmode),
      .o_dwd_icsync   (o_dwd_icsync),
      .o_dwd_ocsync   (o_dwd_ocsync),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Scoreboard entries: {renable, icsync, ocsync}; a write is 3'b000.
   logic [2:0] exp_q[$];
   logic [2:0] e, got;

   int nw, nr, nics, nocs, n_done, done_cyc;
   int first_wen, last_wen, first_ren, last_ren, first_en, last_en;

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops the scoreboard on every enable cycle.
   initial begin
      n_done = 0;
      done_cyc = -1;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (o_dwd_wenable & o_dwd_renable) begin
               checks++; errors++;
               $display("FAIL enable_excl cyc=%0d wen=1 ren=1 required not both", cyc);
            end
            if (o_dwd_wenable | o_dwd_renable) begin
               checks++;
               if (first_en < 0) first_en = cyc;
               last_en = cyc;
               if (o_dwd_wenable) begin
                  nw++;
                  if (first_wen < 0) first_wen = cyc;
                  last_wen = cyc;
               end
               if (o_dwd_renable) begin
                  nr++;
                  if (first_ren < 0) first_ren = cyc;
                  last_ren = cyc;
               end
               if (o_dwd_icsync) nics++;
               if (o_dwd_ocsync) nocs++;
               got = {o_dwd_renable, o_dwd_icsync, o_dwd_ocsync};
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected cyc=%0d got=%b required no enable", cyc, got);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     errors++;
                     $display("FAIL sb_enable cyc=%0d got {ren,ics,ocs}=%b required %b", cyc, got, e);
                  end
               end
            end else if (o_dwd_icsync | o_dwd_ocsync) begin
               checks++; errors++;
               $display("FAIL sync_without_read cyc=%0d ics=%b ocs=%b required 0", cyc, o_dwd_icsync, o_dwd_ocsync);
            end
            if (o_done) begin
               n_done++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      nw = 0; nr = 0; nics = 0; nocs = 0;
      first_wen = -1; last_wen = -1; first_ren = -1; last_ren = -1;
      first_en = -1; last_en = -1;
   endtask

   task automatic push_pass(input int icnt, input int ocnt, input int len);
      for (int o = 0; o <= ocnt; o++) begin
         for (int i = 0; i <= icnt; i++) begin
            for (int r = 0; r <= len; r++) exp_q.push_back(3'b000);
            for (int r = 0; r <= len; r++)
               exp_q.push_back({1'b1, (r == 0), ((r == len) && (i == icnt))});
         end
      end
   endtask

   task automatic send_cmd(input int icnt, input int ocnt, input int len,
                           input logic [1:0] rm, output int t);
      int k;
      k = 0;
      while (!o_cmd_rdy && k < 300) begin
         tick();
         k++;
      end
      checks++;
      if (o_cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL cmd_rdy_wait got=%b required 1", o_cmd_rdy);
      end
      i_cmd_icnt  = 12'(icnt);
      i_cmd_ocnt  = 12'(ocnt);
      i_cmd_len   = 12'(len);
      i_cmd_rmode = rm;
      i_cmd_vld   = 1'b1;
      t = cyc;
      tick();
      i_cmd_vld = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0;
      int k;
      n0 = n_done;
      k = 0;
      while (n_done == n0 && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (n_done == n0) begin
         errors++;
         $display("FAIL done_timeout got no o_done within %0d cycles required o_done", budget);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) tick();
      checks++;
      if ({o_cmd_rdy, o_busy, o_done, o_dwd_wenable, o_dwd_renable} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got rdy,busy,done,wen,ren=%b required 10000",
                  {o_cmd_rdy, o_busy, o_done, o_dwd_wenable, o_dwd_renable});
      end
      checks++;
      if ({o_dwd_rmode, o_dwd_icsync, o_dwd_ocsync} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_dwd got rmode,ics,ocs=%b required 0000",
                  {o_dwd_rmode, o_dwd_icsync, o_dwd_ocsync});
      end
      rstn = 1'b1;
      repeat (2) tick();
      checks++;
      if ({o_cmd_rdy, o_busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_idle got rdy,busy=%b required 10", {o_cmd_rdy, o_busy});
      end
   endtask

   task automatic test_single();
      int t;
      clear_stats();
      i_ltc_vld = 1'b1;
      i_stall = 1'b0;
      push_pass(0, 0, 3);
      send_cmd(0, 0, 3, 2'd2, t);
      checks++;
      if (o_busy !== 1'b1 || o_cmd_rdy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy got busy=%b rdy=%b required 1 0", o_busy, o_cmd_rdy);
      end
      wait_done(100);
      checks++;
      if (first_wen !== t + 2) begin
         errors++;
         $display("FAIL single_first_wen got cyc %0d required %0d", first_wen, t + 2);
      end
      checks++;
      if (nw !== 4 || nr !== 4) begin
         errors++;
         $display("FAIL single_counts got wen=%0d ren=%0d required 4 4", nw, nr);
      end
      checks++;
      if (first_ren !== last_wen + 1) begin
         errors++;
         $display("FAIL single_no_bubble got first ren %0d required %0d", first_ren, last_wen + 1);
      end
      checks++;
      if (done_cyc !== last_ren + 9) begin
         errors++;
         $display("FAIL single_done_lat got cyc %0d required %0d", done_cyc, last_ren + 9);
      end
      checks++;
      if (o_cmd_rdy !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_after_done got rdy=%b busy=%b required 1 0", o_cmd_rdy, o_busy);
      end
      checks++;
      if (o_dwd_rmode !== 2'd2) begin
         errors++;
         $display("FAIL single_rmode got %0d required 2", o_dwd_rmode);
      end
   endtask

   task automatic test_nested();
      int t;
      clear_stats();
      push_pass(1, 1, 1);
      send_cmd(1, 1, 1, 2'd1, t);
      wait_done(200);
      checks++;
      if (nw !== 8 || nr !== 8) begin
         errors++;
         $display("FAIL nested_counts got wen=%0d ren=%0d required 8 8", nw, nr);
      end
      checks++;
      if (last_en - first_en !== 15) begin
         errors++;
         $display("FAIL nested_contig got span %0d required 15", last_en - first_en);
      end
      checks++;
      if (nics !== 4 || nocs !== 2) begin
         errors++;
         $display("FAIL nested_syncs got ics=%0d ocs=%0d required 4 2", nics, nocs);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL nested_sb_left got %0d entries required 0", exp_q.size());
      end
   endtask

   task automatic test_gaps();
      int t;
      int n0;
      clear_stats();
      push_pass(0, 0, 3);
      i_stall = 1'b1;
      i_ltc_vld = 1'b0;
      n0 = n_done;
      send_cmd(0, 0, 3, 2'd0, t);
      for (int k = 0; k < 200 && n_done == n0; k++) begin
         i_ltc_vld = cyc[0];
         i_stall = (nw < 4) || (cyc < last_wen + 3);
         tick();
      end
      i_stall = 1'b0;
      i_ltc_vld = 1'b1;
      checks++;
      if (n_done == n0) begin
         errors++;
         $display("FAIL gaps_done_timeout got no o_done required o_done");
      end
      checks++;
      if (nw !== 4 || nr !== 4) begin
         errors++;
         $display("FAIL gaps_counts got wen=%0d ren=%0d required 4 4", nw, nr);
      end
      checks++;
      if (last_wen - first_wen !== 6) begin
         errors++;
         $display("FAIL gaps_wen_span got %0d required 6", last_wen - first_wen);
      end
      checks++;
      if (first_ren !== last_wen + 4) begin
         errors++;
         $display("FAIL gaps_stalled_read got cyc %0d required %0d", first_ren, last_wen + 4);
      end
      checks++;
      if (nics !== 1 || nocs !== 1) begin
         errors++;
         $display("FAIL gaps_syncs got ics=%0d ocs=%0d required 1 1", nics, nocs);
      end
   endtask

   task automatic test_degenerate();
      int t;
      clear_stats();
      push_pass(0, 0, 0);
      send_cmd(0, 0, 0, 2'd3, t);
      wait_done(100);
      checks++;
      if (nw !== 1 || nr !== 1 || nics !== 1 || nocs !== 1) begin
         errors++;
         $display("FAIL degen_counts got w=%0d r=%0d ics=%0d ocs=%0d required 1 1 1 1",
                  nw, nr, nics, nocs);
      end
      checks++;
      if (done_cyc !== last_ren + 9) begin
         errors++;
         $display("FAIL degen_done_lat got cyc %0d required %0d", done_cyc, last_ren + 9);
      end
      repeat (5) tick();
      checks++;
      if (o_dwd_rmode !== 2'd3) begin
         errors++;
         $display("FAIL degen_rmode_hold got %0d required 3", o_dwd_rmode);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      int acc_c[2];
      int d_at;
      int n_at;
      int bad_busy;
      int n0;
      clear_stats();
      push_pass(0, 1, 2);
      push_pass(0, 1, 2);
      acc = 0; d_at = -1; n_at = 0; bad_busy = 0;
      acc_c[0] = -1; acc_c[1] = -1;
      n0 = n_done;
      i_cmd_icnt = 12'd0;
      i_cmd_ocnt = 12'd1;
      i_cmd_len = 12'd2;
      i_cmd_rmode = 2'd1;
      i_cmd_vld = 1'b1;
      for (int k = 0; k < 400 && acc < 2; k++) begin
         if (o_cmd_rdy) begin
            acc_c[acc] = cyc;
            acc++;
            d_at = done_cyc;
            n_at = n_done;
         end else if (acc == 1 && !o_busy) begin
            bad_busy++;
         end
         tick();
      end
      i_cmd_vld = 1'b0;
      checks++;
      if (acc !== 2) begin
         errors++;
         $display("FAIL b2b_accepts got %0d required 2", acc);
      end
      checks++;
      if (n_at !== n0 + 1 || acc_c[1] !== d_at + 1) begin
         errors++;
         $display("FAIL b2b_second_accept got cyc %0d (dones %0d) required %0d (dones %0d)",
                  acc_c[1], n_at - n0, d_at + 1, 1);
      end
      checks++;
      if (bad_busy !== 0) begin
         errors++;
         $display("FAIL b2b_busy_gap got %0d idle cycles required 0", bad_busy);
      end
      wait_done(200);
      checks++;
      if (nw !== 12 || nr !== 12 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_counts got w=%0d r=%0d left=%0d required 12 12 0", nw, nr, exp_q.size());
      end
      checks++;
      if (o_dwd_rmode !== 2'd1) begin
         errors++;
         $display("FAIL b2b_rmode got %0d required 1", o_dwd_rmode);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      int n0;
      clear_stats();
      i_ltc_vld = 1'b1;
      i_stall = 1'b0;
      push_pass(0, 0, 7);
      send_cmd(0, 0, 7, 2'd2, t);
      for (int k = 0; k < 100 && nr < 2; k++) tick();
      checks++;
      if (nr < 2) begin
         errors++;
         $display("FAIL rstmid_reach_stream got %0d reads required 2", nr);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({o_dwd_wenable, o_dwd_renable, o_dwd_icsync, o_dwd_ocsync, o_busy, o_done} !== 6'b0) begin
         errors++;
         $display("FAIL rstmid_outputs got wen,ren,ics,ocs,busy,done=%b required 000000",
                  {o_dwd_wenable, o_dwd_renable, o_dwd_icsync, o_dwd_ocsync, o_busy, o_done});
      end
      checks++;
      if (o_cmd_rdy !== 1'b1 || o_dwd_rmode !== 2'd0) begin
         errors++;
         $display("FAIL rstmid_rdy_rmode got rdy=%b rmode=%0d required 1 0", o_cmd_rdy, o_dwd_rmode);
      end
      exp_q.delete();
      n0 = n_done;
      tick();
      tick();
      rstn = 1'b1;
      repeat (40) tick();
      checks++;
      if (n_done !== n0) begin
         errors++;
         $display("FAIL rstmid_no_done got %0d dones required 0", n_done - n0);
      end
      checks++;
      if (o_cmd_rdy !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle got rdy=%b busy=%b required 1 0", o_cmd_rdy, o_busy);
      end
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_single();
      test_nested();
      test_gaps();
      test_degenerate();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aixh_mxc_left_seq.md
# aixh_mxc_left_seq

Sequencer for the MxConv left column. It accepts one layer-pass command over a valid/ready handshake and expands it into the vertical control stream at the top of the left queue-tile chain: `wenable`, `renable`, `rmode`, `icsync` and `ocsync`. It walks a nested output-group / input-group loop. Each group runs a FILL phase that writes queue tiles from LTC, followed by a STREAM phase that reads them towards the processing tiles. It sits between the MxConv command decoder and the top of the left column.

## Interface
Parameters:
- `CNT_W`, default 12: width of every loop counter and length field.
- `DRAIN_LAT`, default 8: idle cycles after the last STREAM cycle before `o_done`. Legal range is 1..255.

Ports:
- `aixh_core_clk`  in  1: core clock; the only clock.
- `aixh_core_rstn`  in  1: asynchronous, active-low reset.
- `i_cmd_vld`  in  1: command valid.
- `o_cmd_rdy`  out  1: command ready; high only in IDLE.
- `i_cmd_icnt`  in  `CNT_W`: number of input-channel groups minus 1.
- `i_cmd_ocnt`  in  `CNT_W`: number of output-channel groups minus 1.
- `i_cmd_len`  in  `CNT_W`: rows per group minus 1.
- `i_cmd_rmode`  in  2: read mode for the pass.
- `i_ltc_vld`  in  1: LTC read data is available this cycle (OR of the slice valids).
- `i_stall`  in  1: downstream backpressure; holds STREAM.
- `o_dwd_wenable`  out  1: queue write enable.
- `o_dwd_renable`  out  1: queue read enable.
- `o_dwd_rmode`  out  2: read mode, latched at command acceptance.
- `o_dwd_icsync`  out  1: input-group boundary pulse.
- `o_dwd_ocsync`  out  1: output-group boundary pulse.
- `o_busy`  out  1: high from acceptance until the `o_done` cycle, inclusive.
- `o_done`  out  1: one-cycle pass-complete pulse.

## Operation
- States are IDLE, FILL, STREAM, DRAIN and DONE.
- **IDLE:**
  - `o_cmd_rdy` is 1.
  - When `i_cmd_vld & o_cmd_rdy`, latch `icnt`, `ocnt`, `len` and `rmode`, clear the `ic`, `oc` and `row` counters, and go to FILL.
- **FILL:**
  - Each cycle with `i_ltc_vld`=1 issues one `o_dwd_wenable` and advances `row`.
  - Cycles with `i_ltc_vld`=0 issue nothing; `row` holds.
  - After write number `len+1`, clear `row` and go to STREAM.
- **STREAM:**
  - Each cycle with `i_stall`=0 issues one `o_dwd_renable` and advances `row`.
  - Cycles with `i_stall`=1 issue nothing; `row` holds.
  - `o_dwd_icsync` accompanies the first issued read of every input group.
  - `o_dwd_ocsync` accompanies the last issued read when `ic==icnt`.
  - After read number `len+1`, apply the group step:
    - If `ic<icnt`: `ic++` and go to FILL.
    - Else if `oc<ocnt`: `ic=0`, `oc++` and go to FILL.
    - Else go to DRAIN.
- **DRAIN:** count `DRAIN_LAT` cycles, then go to DONE.
- **DONE:** assert `o_done` for one cycle, then go to IDLE.
- `o_dwd_rmode` holds the latched value until the next accepted command.
- Commands presented while busy are not accepted and not lost; `i_cmd_vld` may stay high.
- Counters compare with `==` against the latched minus-1 fields, so no overflow is possible. All-ones fields are legal and give 2^`CNT_W` iterations.
- `o_dwd_wenable` and `o_dwd_renable` are never high in the same cycle.

## Timing
- All outputs are flops.
- Reset value is 0 for every output except `o_cmd_rdy`, which resets to 1. State resets to IDLE.
- Command accepted in cycle t with `i_ltc_vld`=1 → first `o_dwd_wenable` in cycle t+2.
- `i_ltc_vld` or `i_stall` sampled in cycle c affects the enables in cycle c+1. The internal advance decision and the enable output stay consistent.
- FILL→STREAM and STREAM→FILL transitions add no bubble: with no stalls, the enables are contiguous.
- When `len=0` and `icnt=0`, `icsync` and `ocsync` fire on the same renable cycle.
- A stall asserted on the cycle that would carry `icsync` delays the pulse with that read; the pulse is never duplicated or dropped.
- Reset asserted mid-pass clears everything asynchronously. The pass is discarded and no `o_done` is issued.
- `o_done` is in cycle L+`DRAIN_LAT`+1, where L is the cycle of the last renable. `o_cmd_rdy` rises in the cycle after `o_done`.

## Structure
- Add the state enum type `mxc_lseq_state_t` (5 states) to `AIXH_MXC_pkg`.
- Add the command struct type `mxc_lseq_cmd_t` (`icnt`, `ocnt`, `len`, `rmode`) to the same package.
- One sub-module, `aixh_mxc_left_seq_cnt`: the nested `row`/`ic`/`oc` counter with advance enable, clear, and `last_row` / `last_ic` / `last_oc` flags.
- The FSM and output registers stay in the top module.

## Test plan
- **Single group, no stall.** `icnt=0`, `ocnt=0`, `len=3`, `i_ltc_vld`=1, `i_stall`=0 → 4 wenables, then 4 renables. `icsync` on renable 1, `ocsync` on renable 4. `o_done` 9 cycles after renable 4 (`DRAIN_LAT`=8).
- **Nested groups.** `icnt=1`, `ocnt=1`, `len=1` → W W R R repeated 4×, 16 contiguous enable cycles. 4 `icsync` and 2 `ocsync` (on enable cycles 8 and 16).
- **Gaps and backpressure.** `i_ltc_vld` toggling 1/0, `i_stall` high for 3 cycles on the first read → exactly `len+1` writes and `len+1` reads. `icsync` lands on the delayed first read.
- **Degenerate command.** `len=0`, `icnt=0`, `ocnt=0` → one wenable, one renable carrying both `icsync` and `ocsync`. `o_dwd_rmode` equals the command's `rmode` until the next command.
- **Back-to-back and busy handling.** `i_cmd_vld` held high across two commands → the second is accepted the cycle after `o_done`, and `o_cmd_rdy`=0 throughout the first pass.
- **Reset mid-pass.** Assert `aixh_core_rstn`=0 during STREAM → outputs 0 immediately, no `o_done`, and `o_cmd_rdy`=1 after release.
